// File: rtl/axioma_timer_prescaler_ctrl_pkg.sv
// Shared definitions for the Timer0/Timer1 prescaler controller: clock-select codes,
// GTCCR address and bit positions, and the tick-decode and GTCCR helpers.
package axioma_timer_prescaler_ctrl_pkg;

   typedef enum logic [2:0] {
      CS_STOP     = 3'b000,
      CS_DIV1     = 3'b001,
      CS_DIV8     = 3'b010,
      CS_DIV64    = 3'b011,
      CS_DIV256   = 3'b100,
      CS_DIV1024  = 3'b101,
      CS_EXT_FALL = 3'b110,
      CS_EXT_RISE = 3'b111
   } cs_e;

   localparam logic [5:0]  ADDR_GTCCR    = 6'h23;
   localparam int unsigned GTCCR_TSM     = 7;
   localparam int unsigned GTCCR_PSRASY  = 1;
   localparam int unsigned GTCCR_PSRSYNC = 0;
   localparam int unsigned PRESCALE_W    = 10;

   typedef struct packed {
      logic tsm;
      logic psrsync;
   } gtccr_t;

   // PSRASY and the reserved bits have no storage and always read back as 0.
   function automatic logic [7:0] gtccr_read(input gtccr_t g);
      logic [7:0] v;
      v                = 8'h00;
      v[GTCCR_TSM]     = g.tsm;
      v[GTCCR_PSRSYNC] = g.psrsync;
      return v;
   endfunction

   // With TSM set, PSRSYNC is sticky until a write clears TSM; otherwise it self-clears.
   function automatic gtccr_t gtccr_next(input gtccr_t cur, input logic wr, input logic [7:0] d);
      gtccr_t nxt;
      nxt = cur;
      if (wr) begin
         nxt.tsm     = d[GTCCR_TSM];
         nxt.psrsync = d[GTCCR_PSRSYNC] | (cur.psrsync & d[GTCCR_TSM]);
      end else begin
         nxt.tsm     = cur.tsm;
         nxt.psrsync = cur.psrsync & cur.tsm;
      end
      return nxt;
   endfunction

   function automatic logic tick_decode(input logic [2:0] cs,
                                        input logic [PRESCALE_W-1:0] cnt,
                                        input logic held,
                                        input logic rise,
                                        input logic fall);
      logic tick;
      tick = 1'b0;
      case (cs_e'(cs))
         CS_STOP:     tick = 1'b0;
         CS_DIV1:     tick = ~held;
         CS_DIV8:     tick = ~held & (cnt[2:0] == 3'b111);
         CS_DIV64:    tick = ~held & (cnt[5:0] == 6'h3F);
         CS_DIV256:   tick = ~held & (cnt[7:0] == 8'hFF);
         CS_DIV1024:  tick = ~held & (cnt[9:0] == 10'h3FF);
         CS_EXT_FALL: tick = fall;
         CS_EXT_RISE: tick = rise;
         default:     tick = 1'b0;
      endcase
      return tick;
   endfunction

endpackage

// File: rtl/axioma_timer_prescaler_ctrl_if.sv
// I/O-bus port group for the GTCCR register of the timer prescaler controller.
interface axioma_timer_prescaler_ctrl_if;
   logic [5:0] io_addr;
   logic [7:0] io_data_in;
   logic [7:0] io_data_out;
   logic       io_read;
   logic       io_write;

   modport master (
      output io_addr,
      output io_data_in,
      output io_read,
      output io_write,
      input  io_data_out
   );

   modport slave (
      input  io_addr,
      input  io_data_in,
      input  io_read,
      input  io_write,
      output io_data_out
   );
endinterface

// File: rtl/axioma_ext_clk_sync.sv
// Two-flop synchroniser for an external timer clock pin, followed by a previous-value
// flop whose comparison yields single-cycle rise/fall indications.
module axioma_ext_clk_sync (
   input  logic clk,
   input  logic reset_n,
   input  logic i_pin,
   output logic o_rise,
   output logic o_fall
);

   logic r_sync1;
   logic r_sync2;
   logic r_prev;

   // Synchroniser chain; reset to 0 so a pin held high through reset gives one rise.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_prev  <= 1'b0;
      end else begin
         r_sync1 <= i_pin;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   assign o_rise = r_sync2 & ~r_prev;
   assign o_fall = ~r_sync2 & r_prev;

endmodule

// File: rtl/axioma_timer_prescaler_ctrl_chk.sv
// Invariant checker for the prescaler controller: hold behaviour, stopped timers,
// read-data gating and tick alignment between timers sharing a prescaled CS.
module axioma_timer_prescaler_ctrl_chk
   import axioma_timer_prescaler_ctrl_pkg::*;
(
   input logic                  clk,
   input logic                  reset_n,
   input logic [2:0]            i_cs0,
   input logic [2:0]            i_cs1,
   input logic                  i_io_read,
   input logic [5:0]            i_io_addr,
   input logic [7:0]            i_io_data_out,
   input logic                  i_psrsync,
   input logic [PRESCALE_W-1:0] i_prescale,
   input logic                  i_tick0,
   input logic                  i_tick1
);

   logic w_same_div;
   assign w_same_div = (i_cs0 == i_cs1) && (i_cs0 != CS_EXT_FALL) && (i_cs0 != CS_EXT_RISE);

   a_hold_clears: assert property (@(posedge clk) disable iff (!reset_n)
      i_psrsync |=> (i_prescale == 10'd0));

   a_stop0: assert property (@(posedge clk) disable iff (!reset_n)
      (i_cs0 == CS_STOP) |=> !i_tick0);

   a_stop1: assert property (@(posedge clk) disable iff (!reset_n)
      (i_cs1 == CS_STOP) |=> !i_tick1);

   a_rd_idle: assert property (@(posedge clk) disable iff (!reset_n)
      !(i_io_read && (i_io_addr == ADDR_GTCCR)) |-> (i_io_data_out == 8'h00));

   a_psrasy_zero: assert property (@(posedge clk) disable iff (!reset_n)
      (i_io_data_out[GTCCR_PSRASY] == 1'b0) && (i_io_data_out[6:2] == 5'b00000));

   a_aligned: assert property (@(posedge clk) disable iff (!reset_n)
      w_same_div |=> (i_tick0 == i_tick1));

endmodule

// File: rtl/axioma_timer_prescaler_ctrl.sv
// Shared Timer0/Timer1 prescaler and clock-select controller: GTCCR (TSM, PSRSYNC),
// 10-bit prescaler, external T0/T1 synchronisers and registered count-enable ticks.
module axioma_timer_prescaler_ctrl
   import axioma_timer_prescaler_ctrl_pkg::*;
(
   input  logic                            clk,
   input  logic                            reset_n,
   axioma_timer_prescaler_ctrl_if.slave    io,
   input  logic [2:0]                      i_cs0,
   input  logic [2:0]                      i_cs1,
   input  logic                            i_t0_pin,
   input  logic                            i_t1_pin,
   output logic                            o_timer0_tick,
   output logic                            o_timer1_tick,
   output logic [PRESCALE_W-1:0]           o_debug_prescale,
   output logic                            o_debug_psrsync
);

   gtccr_t                r_gtccr;
   logic [PRESCALE_W-1:0] r_prescale;
   logic                  r_tick0;
   logic                  r_tick1;
   logic                  w_gtccr_wr;
   logic [7:0]            w_rd_data;
   logic                  w_t0_rise;
   logic                  w_t0_fall;
   logic                  w_t1_rise;
   logic                  w_t1_fall;

   axioma_ext_clk_sync u_t0_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .i_pin   (i_t0_pin),
      .o_rise  (w_t0_rise),
      .o_fall  (w_t0_fall)
   );

   axioma_ext_clk_sync u_t1_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .i_pin   (i_t1_pin),
      .o_rise  (w_t1_rise),
      .o_fall  (w_t1_fall)
   );

   // GTCCR address decode for write strobe and combinational read data.
   always_comb begin
      w_gtccr_wr = 1'b0;
      w_rd_data  = 8'h00;
      if (io.io_write && (io.io_addr == ADDR_GTCCR)) begin
         w_gtccr_wr = 1'b1;
      end else begin
         w_gtccr_wr = 1'b0;
      end
      if (io.io_read && (io.io_addr == ADDR_GTCCR)) begin
         w_rd_data = gtccr_read(r_gtccr);
      end else begin
         w_rd_data = 8'h00;
      end
   end

   assign io.io_data_out = w_rd_data;

   // GTCCR state, updated on every edge whether or not it is written.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_gtccr <= gtccr_t'(2'b00);
      end else begin
         r_gtccr <= gtccr_next(r_gtccr, w_gtccr_wr, io.io_data_in);
      end
   end

   // Shared prescaler: cleared and held while PSRSYNC is set, free-running wrap otherwise.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_prescale <= 10'd0;
      end else if (r_gtccr.psrsync) begin
         r_prescale <= 10'd0;
      end else begin
         r_prescale <= r_prescale + 10'd1;
      end
   end

   // Registered count-enable ticks; both timers decode against the same counter state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_tick0 <= 1'b0;
         r_tick1 <= 1'b0;
      end else begin
         r_tick0 <= tick_decode(i_cs0, r_prescale, r_gtccr.psrsync, w_t0_rise, w_t0_fall);
         r_tick1 <= tick_decode(i_cs1, r_prescale, r_gtccr.psrsync, w_t1_rise, w_t1_fall);
      end
   end

   assign o_timer0_tick    = r_tick0;
   assign o_timer1_tick    = r_tick1;
   assign o_debug_prescale = r_prescale;
   assign o_debug_psrsync  = r_gtccr.psrsync;

   axioma_timer_prescaler_ctrl_chk u_chk (
      .clk           (clk),
      .reset_n       (reset_n),
      .i_cs0         (i_cs0),
      .i_cs1         (i_cs1),
      .i_io_read     (io.io_read),
      .i_io_addr     (io.io_addr),
      .i_io_data_out (w_rd_data),
      .i_psrsync     (r_gtccr.psrsync),
      .i_prescale    (r_prescale),
      .i_tick0       (r_tick0),
      .i_tick1       (r_tick1)
   );

endmodule

// File: doc/axioma_timer_prescaler_ctrl.md
# axioma_timer_prescaler_ctrl

Shared synchronous prescaler and clock-select controller for Timer/Counter 0 and Timer/Counter 1, ATmega328P compatible. It owns the GTCCR register (TSM, PSRSYNC) on the I/O bus, runs the single 10-bit prescaler both timers share, and synchronises the external T0/T1 clock pins. From each timer's CSn[2:0] field it produces a one-cycle count-enable pulse per timer. It lets software halt and restart both timers in lock-step.

## Interface
- No parameters; all widths fixed by ATmega328P compatibility.
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- io_addr  in  6  I/O address; GTCCR = 6'h23 (data space 0x43)
- io_data_in  in  8  write data
- io_data_out  out  8  read data; 0 unless io_read and io_addr = GTCCR
- io_read  in  1  read strobe
- io_write  in  1  write strobe, one cycle per write
- cs0  in  3  Timer0 clock select (TCCR0B[2:0])
- cs1  in  3  Timer1 clock select (TCCR1B[2:0])
- t0_pin  in  1  external clock T0 (PD4), asynchronous
- t1_pin  in  1  external clock T1 (PD5), asynchronous
- timer0_tick  out  1  registered count-enable pulse for Timer0
- timer1_tick  out  1  registered count-enable pulse for Timer1
- debug_prescale  out  10  current prescaler count
- debug_psrsync  out  1  current PSRSYNC state

## Operation
- GTCCR layout: bit7 TSM, bit0 PSRSYNC, bit1 PSRASY, bits6:2 reserved.
  - PSRASY belongs to Timer2; writes to it are ignored and it reads 0.
  - Reserved bits read 0.
- Read value: {tsm, 6'b0, psrsync}. io_data_out is combinational.
- GTCCR update, applied on every clk edge:
  - On a GTCCR write: tsm <= d[7]; psrsync <= d[0] | (psrsync & d[7]).
  - Otherwise: psrsync <= psrsync & tsm.
  - Resulting behaviour:
    - With TSM=0, writing PSRSYNC=1 gives a one-cycle reset pulse.
    - With TSM=1, PSRSYNC stays set until a write with d[7]=0.
    - A write of 0x00 clears both bits at that edge.
- Prescaler:
  - 10-bit counter, cleared to 0 and held while psrsync=1.
  - Otherwise it increments every cycle and wraps 1023 -> 0.
- Internal tick condition, with held = psrsync:
  - CS=000: timer stopped, never ticks.
  - CS=001: !held.
  - CS=010: !held & cnt[2:0]==7.
  - CS=011: !held & cnt[5:0]==63.
  - CS=100: !held & cnt[7:0]==255.
  - CS=101: !held & cnt[9:0]==1023.
- External clock path, one per timer:
  - Two-flop synchroniser, then a previous-value flop.
  - CS=110 ticks on a falling edge; CS=111 ticks on a rising edge.
  - External ticks are not gated by PSRSYNC or TSM.
- A change of CS takes effect on the next edge. It never resets the prescaler.
- Both timers decode against the same counter, so equal CS values produce identical, aligned ticks.

## Timing
- Reset values:
  - tsm=0, psrsync=0, prescaler=0.
  - All synchroniser and edge flops = 0.
  - timer0_tick=0, timer1_tick=0, debug outputs 0.
- Ticks are registered: the condition is evaluated on the cycle-N state and the tick appears in cycle N+1, one cycle wide.
- Restart latency: take c1 as the first cycle with psrsync=0 (count=0). A /N tick first appears N cycles after c1 and then every N cycles.
  - Example: the /1 tick first appears in c2; the /8 tick first appears in c9.
- External latency: a pin edge produces its tick 3 clk cycles later. Pulses shorter than 2 clk periods may be lost.
- Power-up edge: the synchroniser resets to 0, so a pin held high through reset yields exactly one rising-edge tick when CS=111.
- Back-to-back GTCCR writes are each applied on their own edge. There is no write buffering.
- Reset asserted mid-count clears everything immediately. Reset release acts as a prescaler restart with c1 = the first clocked cycle.

## Structure
- Shared package holds:
  - CS codes: CS_STOP, CS_DIV1, CS_DIV8, CS_DIV64, CS_DIV256, CS_DIV1024, CS_EXT_FALL, CS_EXT_RISE.
  - ADDR_GTCCR and the GTCCR bit indices (GTCCR_TSM, GTCCR_PSRSYNC, GTCCR_PSRASY).
- Sub-module axioma_ext_clk_sync: synchroniser plus edge detector producing rise/fall pulses. Instantiated twice, for T0 and T1.
- Tick decode is a function of (cs, cnt, held, rise, fall). Write it once and use it for both timers.

## Test plan
- Reset, then cs0=010 with no writes: timer0_tick high on cycles 9, 17, 25…; debug_prescale wraps 1023 -> 0.
- Write GTCCR=0x81, then wait 100 cycles: both ticks stay 0 and debug_prescale=0; reading GTCCR returns 0x81.
- Write 0x00 with cs0=cs1=011: psrsync clears at that edge; both ticks rise together 64 cycles after release.
- Write 0x01 with TSM=0: psrsync is high for exactly one cycle and the prescaler restarts from 0; a subsequent read returns 0x00.
- cs1=111 with t1_pin toggled every 10 cycles: one tick per rising edge, 3 cycles after the edge, unaffected by a TSM hold.
- Write 0xFE: bit1 and the reserved bits are ignored; readback is 0x80.
